// File: rtl/sort_host.sv
// rtl/sort_host.sv - stream host for the fsm_sort engine: fill, kick, wait, drain
// Optional watchdog compiled in with SORT_HOST_TIMEOUT_EN.
module sort_host #(
    parameter int N       = 6,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sort_start,
    output logic [WIDTH-1:0] sort_data_in [N],
    input  logic             sort_done,
    input  logic [WIDTH-1:0] sort_data_sorted [N],
    output logic             busy,
    output logic             error
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {FILL, KICK, WAIT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] load [N];
    logic [WIDTH-1:0] res  [N];
    logic             in_fire;
    logic             out_fire;
    logic             timeout_hit;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef SORT_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic          error_q;

    // sort_done wins over a watchdog expiry landing in the same cycle
    assign timeout_hit = (state == WAIT) && !sort_done && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == WAIT && !sort_done && !timeout_hit)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (timeout_hit)
                error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sort_start = 1'b0;
        busy       = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_idx == LAST_IDX)
                    state_nxt = KICK;
            end
            KICK: begin
                sort_start = 1'b1;
                busy       = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (sort_done)
                    state_nxt = DRAIN;
                else if (timeout_hit)
                    state_nxt = FILL;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && rd_idx == LAST_IDX)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            for (int k = 0; k < N; k++) begin
                load[k] <= '0;
                res[k]  <= '0;
            end
        end else begin
            if (in_fire) begin
                load[wr_idx] <= in_data;
                wr_idx       <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end
            if (state == WAIT && sort_done) begin
                for (int k = 0; k < N; k++)
                    res[k] <= sort_data_sorted[k];
                rd_idx <= '0;
            end else if (out_fire) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
            // an abandoned job must not leak its words into the next one
            if (timeout_hit) begin
                for (int k = 0; k < N; k++)
                    load[k] <= '0;
            end
        end
    end

    assign sort_data_in = load;
    assign out_data     = out_valid ? res[rd_idx] : '0;
    assign out_last     = out_valid && (rd_idx == LAST_IDX);

endmodule
